alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle shift-and-add multiplier sequencer that time-shares the pipeline's single combinational ALU.
- Issues ADD, SHIFTL and SHIFTR ops to the ALU one per granted cycle and returns the low data_width bits of A*B.
- The product is mod 2^data_width, so it is correct for signed and unsigned operands alike.
- Sits beside the EX stage. The EX-stage arbiter owns alu_gnt and gives the ALU to the sequencer only on cycles EX does not need it.

Parameters:
- data_width, 32, operand/result width; must match the shared ALU.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- abort  input  1  synchronous cancel (pipeline flush); highest priority after reset
- op_a  input  data_width  multiplicand
- op_b  input  data_width  multiplier
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse; result valid in that cycle
- result  output  data_width  product; holds its value until the next done
- alu_req  output  1  requests the ALU this cycle
- alu_gnt  input  1  ALU granted this cycle; alu_z is consumed in the same cycle
- alu_a  output  data_width  ALU operand A
- alu_b  output  data_width  ALU operand B
- alu_ctrl  output  4  ALU op code
- alu_z  input  data_width  ALU combinational result

Behaviour:
- Registers: acc (partial product), mc (shifted multiplicand), mp (shifted multiplier), iter (6-bit iteration count), state, result.
- Reset (async): state=IDLE, acc=mc=mp=0, iter=0, result=0. Outputs: busy=0, done=0, alu_req=0, alu_ctrl=NOP(0000), alu_a=alu_b=0.
- IDLE: on start, load acc=0, mc=op_a, mp=op_b, iter=0. Next state:
  - op_b==0 -> DONE
  - op_b[0]==1 -> ADD
  - otherwise -> SHL
- ADD: alu_req=1, alu_ctrl=0001, alu_a=acc, alu_b=mc. If alu_gnt: acc<=alu_z and go to SHL. Else hold.
- SHL: alu_req=1, alu_ctrl=0110, alu_a=mc, alu_b=0. If alu_gnt: mc<=alu_z and go to SHR. Else hold.
- SHR: alu_req=1, alu_ctrl=0111, alu_a=mp, alu_b=0. If alu_gnt: mp<=alu_z and iter<=iter+1. Next state:
  - alu_z==0 -> DONE
  - alu_z[0]==1 -> ADD
  - otherwise -> SHL
  - If not granted, hold.
- DONE: result<=acc on entry (registered in the transition cycle). done=1 and busy=1 for exactly this cycle. Next state is IDLE.
- Outputs in IDLE/DONE: alu_req=0, alu_ctrl=NOP, alu_a=alu_b=0. This keeps the ALU output quiet for the arbiter.
- Grant rules:
  - alu_gnt is ignored whenever alu_req=0.
  - Without a grant, the sequencer holds its state and all operand outputs stable.
  - alu_req stays asserted until granted; it is never dropped while waiting.
- Latency, with alu_gnt tied high:
  - start in cycle T -> done in cycle T+1+sum over iterations (3 if the multiplier bit is 1, else 2).
  - op_b==0 -> done at T+1.
  - Worst case op_b=all ones -> done at T+1+3*data_width.
- iter never exceeds data_width, since mp reaches 0 after at most data_width shifts. The bench asserts this.
- start while busy: ignored. No queueing and no effect on the current operation.
- abort in any non-IDLE state: next state IDLE; acc/mc/mp are don't-care; result is unchanged; no done pulse. abort in IDLE has no effect. If abort and start are asserted together in IDLE, start wins.
- Reset mid-operation: immediate return to IDLE with all reset values, including result=0.
- The ALU overflow output is not used. Wrap-around of the partial sum is the intended mod-2^N behaviour.

Decomposition:
- Shared package constants:
  - ALU op codes: NOP=0000, ADD=0001, SHIFTL=0110, SHIFTR=0111. These are the same codes EX decode uses.
  - State encoding: IDLE, ADD, SHL, SHR, DONE, 3-bit.
- No sub-module. The ALU stays a single shared instance at the EX level, and the arbiter's alu_gnt mux lives there, not here.

Test Plan:
- Basic multiply: op_a=3, op_b=5, gnt=1, start in cycle 0 -> ctrl sequence ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR in cycles 1-8; done in cycle 9; result=15.
- Zero and signed operands:
  - op_a=7, op_b=0 -> done in cycle 1, result=0, alu_req never high.
  - op_a=-3, op_b=4 -> result=0xFFFFFFF4.
- Worst case: op_a=op_b=0xFFFFFFFF, gnt=1 -> done in cycle 97, result=0x00000001, iter=32.
- Grant stalls: 3*5 with alu_gnt low on alternate cycles -> identical ctrl order; alu_a/alu_ctrl stable during stalls; result=15; done in cycle 17.
- start while busy: op_a=6, op_b=7, then start again with op_a=2, op_b=2 at cycle 3 -> result=42; exactly one done pulse.
- Abort and reset:
  - abort at cycle 4 of 3*5 -> busy=0 at cycle 5; no done; result keeps its prior value.
  - Async reset pulse mid-operation (between clock edges) -> outputs reach reset values immediately; a following start of 2*3 gives result=6.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the shift-and-add multiply sequencer.
// The ALU op codes must stay identical to the ones EX decode drives.
package alu_mul_seq_pkg;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SHL = 4'b0110;
  localparam logic [3:0] ALU_SHR = 4'b0111;

  localparam int ITER_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADD  = 3'd1,
    ST_SHL  = 3'd2,
    ST_SHR  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle multiplier that borrows the shared EX ALU on granted cycles
// and returns the low data_width bits of op_a*op_b.
//
// state | meaning
// IDLE  | waiting for start; ALU outputs quiet
// ADD   | acc <= acc + mc (current multiplier bit is 1)
// SHL   | mc  <= mc << 1
// SHR   | mp  <= mp >> 1, iteration complete
// DONE  | result valid, one-cycle done pulse
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [data_width-1:0] op_a,
  input  logic [data_width-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] result,
  output logic                  alu_req,
  input  logic                  alu_gnt,
  output logic [data_width-1:0] alu_a,
  output logic [data_width-1:0] alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [data_width-1:0] alu_z
);

  state_t                  state;
  state_t                  state_n;
  logic [data_width-1:0]   acc;
  logic [data_width-1:0]   mc;
  logic [data_width-1:0]   mp;
  logic [ITER_W-1:0]       iter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      acc    <= '0;
      mc     <= '0;
      mp     <= '0;
      iter   <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc  <= '0;
            mc   <= op_a;
            mp   <= op_b;
            iter <= '0;
          end
        end
        ST_ADD: if (alu_gnt) acc <= alu_z;
        ST_SHL: if (alu_gnt) mc <= alu_z;
        ST_SHR: begin
          if (alu_gnt) begin
            mp   <= alu_z;
            iter <= iter + 1'b1;
          end
        end
        default: ;
      endcase
      // A zero multiplier skips straight to DONE while acc is still being cleared
      if (state_n == ST_DONE)
        result <= (state == ST_IDLE) ? '0 : acc;
    end
  end

  always_comb begin
    state_n  = state;
    alu_req  = 1'b0;
    alu_ctrl = ALU_NOP;
    alu_a    = '0;
    alu_b    = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op_b == '0)   state_n = ST_DONE;
          else if (op_b[0]) state_n = ST_ADD;
          else              state_n = ST_SHL;
        end
      end
      ST_ADD: begin
        alu_req  = 1'b1;
        alu_ctrl = ALU_ADD;
        alu_a    = acc;
        alu_b    = mc;
        if (alu_gnt) state_n = ST_SHL;
      end
      ST_SHL: begin
        alu_req  = 1'b1;
        alu_ctrl = ALU_SHL;
        alu_a    = mc;
        if (alu_gnt) state_n = ST_SHR;
      end
      ST_SHR: begin
        alu_req  = 1'b1;
        alu_ctrl = ALU_SHR;
        alu_a    = mp;
        if (alu_gnt) begin
          if (alu_z == '0)   state_n = ST_DONE;
          else if (alu_z[0]) state_n = ST_ADD;
          else               state_n = ST_SHL;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // Pipeline flush cancels silently; a start in IDLE is never overridden
    if (abort && (state != ST_IDLE))
      state_n = ST_IDLE;
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural model of the shared ALU.
module tb_alu_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_z;

  int total;
  int bad;

  logic [3:0]  ctrl_log [0:127];
  logic [31:0] a_log    [0:127];
  logic [3:0]  exp_seq  [0:7];

  alu_mul_seq #(.data_width(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_req  (alu_req),
    .alu_gnt  (alu_gnt),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_z    (alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_z = 32'h0;
    case (alu_ctrl)
      4'b0001: alu_z = alu_a + alu_b;
      4'b0110: alu_z = alu_a << 1;
      4'b0111: alu_z = alu_a >> 1;
      default: alu_z = 32'h0;
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      assert (dut.iter <= 6'd32)
      else begin
        $display("FAIL iter_bound got=%0d max=32", dut.iter);
        bad++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Starts an operation in cycle 0 and logs cycles 1..n until a few cycles past done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit stall,
                        input int max_cyc, output int done_cyc, output int n_done,
                        output int n_req, output logic [5:0] iter_done);
    int extra;
    done_cyc  = -1;
    n_done    = 0;
    n_req     = 0;
    iter_done = 6'd0;
    extra     = 0;
    @(negedge clk);
    start   = 1'b1;
    op_a    = a;
    op_b    = b;
    alu_gnt = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start   = 1'b0;
      alu_gnt = stall ? (c % 2 == 0) : 1'b1;
      ctrl_log[c] = alu_ctrl;
      a_log[c]    = alu_a;
      if (alu_req) n_req++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc  = c;
          iter_done = dut.iter;
        end
      end
      if (done_cyc >= 0) begin
        extra++;
        if (extra > 3) break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, alu_req} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, alu_req});
    end
    total++;
    if (alu_ctrl !== 4'b0000 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
      bad++; $display("FAIL reset_alu got ctrl=%h a=%h b=%h exp all zero", alu_ctrl, alu_a, alu_b);
    end
    total++;
    if (result !== 32'h0) begin
      bad++; $display("FAIL reset_result got=%h exp=0", result);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc, nd, nr;
    logic [5:0] it;
    run_op(32'd3, 32'd5, 1'b0, 30, dc, nd, nr, it);
    total++;
    if (dc !== 9) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=9", dc); end
    total++;
    if (result !== 32'd15) begin bad++; $display("FAIL basic_result got=%0d exp=15", result); end
    total++;
    if (nd !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (ctrl_log[k+1] !== exp_seq[k]) begin
        bad++; $display("FAIL basic_ctrl[%0d] got=%b exp=%b", k + 1, ctrl_log[k+1], exp_seq[k]);
      end
    end
  endtask

  task automatic test_zero_signed();
    int dc, nd, nr;
    logic [5:0] it;
    run_op(32'd7, 32'd0, 1'b0, 10, dc, nd, nr, it);
    total++;
    if (dc !== 1) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=1", dc); end
    total++;
    if (result !== 32'd0) begin bad++; $display("FAIL zero_result got=%h exp=0", result); end
    total++;
    if (nr !== 0) begin bad++; $display("FAIL zero_req_cycles got=%0d exp=0", nr); end
    run_op(32'hFFFF_FFFD, 32'd4, 1'b0, 20, dc, nd, nr, it);
    total++;
    if (result !== 32'hFFFF_FFF4) begin bad++; $display("FAIL signed_result got=%h exp=fffffff4", result); end
    total++;
    if (dc !== 8) begin bad++; $display("FAIL signed_done_cycle got=%0d exp=8", dc); end
  endtask

  task automatic test_worst();
    int dc, nd, nr;
    logic [5:0] it;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 110, dc, nd, nr, it);
    total++;
    if (dc !== 97) begin bad++; $display("FAIL worst_done_cycle got=%0d exp=97", dc); end
    total++;
    if (result !== 32'h0000_0001) begin bad++; $display("FAIL worst_result got=%h exp=00000001", result); end
    total++;
    if (it !== 6'd32) begin bad++; $display("FAIL worst_iter got=%0d exp=32", it); end
  endtask

  task automatic test_grant_stall();
    int dc, nd, nr;
    logic [5:0] it;
    run_op(32'd3, 32'd5, 1'b1, 40, dc, nd, nr, it);
    total++;
    if (dc !== 17) begin bad++; $display("FAIL stall_done_cycle got=%0d exp=17", dc); end
    total++;
    if (result !== 32'd15) begin bad++; $display("FAIL stall_result got=%0d exp=15", result); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (ctrl_log[2*k+2] !== exp_seq[k]) begin
        bad++; $display("FAIL stall_ctrl[%0d] got=%b exp=%b", 2 * k + 2, ctrl_log[2*k+2], exp_seq[k]);
      end
      total++;
      if (ctrl_log[2*k+1] !== exp_seq[k] || a_log[2*k+1] !== a_log[2*k+2]) begin
        bad++; $display("FAIL stall_hold[%0d] got ctrl=%b a=%h exp ctrl=%b a=%h", 2 * k + 1,
                        ctrl_log[2*k+1], a_log[2*k+1], exp_seq[k], a_log[2*k+2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc, nd;
    dc = -1;
    nd = 0;
    @(negedge clk);
    start   = 1'b1;
    op_a    = 32'd6;
    op_b    = 32'd7;
    alu_gnt = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 3) begin
        op_a = 32'd2;
        op_b = 32'd2;
      end
      if (done) begin
        nd++;
        if (dc < 0) dc = c;
      end
    end
    start = 1'b0;
    total++;
    if (dc !== 10) begin bad++; $display("FAIL b2b_done_cycle got=%0d exp=10", dc); end
    total++;
    if (result !== 32'd42) begin bad++; $display("FAIL b2b_result got=%0d exp=42", result); end
    total++;
    if (nd !== 1) begin bad++; $display("FAIL b2b_done_count got=%0d exp=1", nd); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    int nd;
    logic busy5;
    nd    = 0;
    busy5 = 1'b1;
    @(negedge clk);
    start   = 1'b1;
    op_a    = 32'd3;
    op_b    = 32'd5;
    alu_gnt = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (c == 4);
      if (c == 5) busy5 = busy;
      if (done) nd++;
    end
    abort = 1'b0;
    total++;
    if (busy5 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy5); end
    total++;
    if (nd !== 0) begin bad++; $display("FAIL abort_done_count got=%0d exp=0", nd); end
    total++;
    if (result !== 32'd42) begin bad++; $display("FAIL abort_result got=%0d exp=42", result); end
    // start and abort together in IDLE: start must win
    start = 1'b1;
    abort = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_start_idle got=%b exp=1", busy); end
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || result !== 32'd42) begin
      bad++; $display("FAIL abort_cleanup got busy=%b result=%0d exp busy=0 result=42", busy, result);
    end
  endtask

  task automatic test_async_reset();
    int dc, nd, nr;
    logic [5:0] it;
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd5;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, alu_req} !== 3'b000 || alu_ctrl !== 4'b0000 || alu_a !== 32'h0) begin
      bad++; $display("FAIL async_reset_outputs got flags=%b ctrl=%b a=%h exp 000/0000/0",
                      {busy, done, alu_req}, alu_ctrl, alu_a);
    end
    total++;
    if (result !== 32'h0) begin bad++; $display("FAIL async_reset_result got=%h exp=0", result); end
    #1;
    reset = 1'b0;
    run_op(32'd2, 32'd3, 1'b0, 20, dc, nd, nr, it);
    total++;
    if (result !== 32'd6) begin bad++; $display("FAIL post_reset_result got=%0d exp=6", result); end
    total++;
    if (dc !== 7) begin bad++; $display("FAIL post_reset_done_cycle got=%0d exp=7", dc); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    op_a    = 32'h0;
    op_b    = 32'h0;
    alu_gnt = 1'b0;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0110; exp_seq[2] = 4'b0111; exp_seq[3] = 4'b0110;
    exp_seq[4] = 4'b0111; exp_seq[5] = 4'b0001; exp_seq[6] = 4'b0110; exp_seq[7] = 4'b0111;
    test_reset();
    test_basic();
    test_zero_signed();
    test_worst();
    test_grant_stall();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
